// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word width and mode-0 constants.
// Also used by spi_slave.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam int unsigned SPI_DATA_W = 8;

  // Mode 0: clock idles low, data is sampled on the rising edge and shifted on the falling edge.
  localparam logic SPI_CPOL    = 1'b0;
  localparam logic SPI_CPHA    = 1'b0;
  localparam logic SCLK_IDLE   = SPI_CPOL;
  localparam logic SS_ACTIVE   = 1'b0;
  localparam logic SS_INACTIVE = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: while enable is high, tick pulses for one cycle every CLK_DIV clk cycles.
// The counter is held at zero while disabled, so every phase starts on a clean count.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == 8'(CLK_DIV - 1));
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first: SETUP, DATA_W clock pulses, HOLD and GAP phases.
// Each phase is CLK_DIV cycles long. All outputs are registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ss_q, ss_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_en;
  logic              tick;

  assign div_en = (state_q != ST_IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .enable(div_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          ss_d      = SS_ACTIVE;
          sclk_d    = SCLK_IDLE;
          mosi_d    = tx_data[DATA_W-1];
          busy_d    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_XFER;
          sclk_d  = ~SCLK_IDLE;
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (sclk_q == SCLK_IDLE) begin
            sclk_d = ~SCLK_IDLE;
          end else begin
            // Falling edge: sample miso, then advance mosi unless this was the last bit.
            sclk_d    = SCLK_IDLE;
            rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso};
            bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              state_d = ST_HOLD;
            end else begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_d[DATA_W-1];
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d   = ST_GAP;
          ss_d      = SS_INACTIVE;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      ss_q      <= SS_INACTIVE;
      sclk_q    <= SCLK_IDLE;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter DATA_W, default 8: bits per transfer.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  transfer request; sampled only in IDLE.
REQ-006 tx_data  input  DATA_W  byte to send; captured on the cycle start is accepted.
REQ-007 rx_data  output  DATA_W  byte received in the last completed transfer.
REQ-008 busy  output  1  high from the cycle after start is accepted until the end of GAP.
REQ-009 done  output  1  one-cycle pulse when a transfer completes.
REQ-010 ss  output  1  slave select, active-low.
REQ-011 sclk  output  1  serial clock, mode 0 (idle low).
REQ-012 mosi  output  1  serial data out, MSB first.
REQ-013 miso  input  1  serial data in, MSB first.

Function
REQ-014 The block SHALL use FSM states IDLE, SETUP, XFER, HOLD and GAP.
REQ-015 IDLE with start=1 SHALL capture tx_data into the tx shift register and move to SETUP; call the next edge T0.
REQ-016 At T0: ss=0, busy=1, mosi=tx_data[DATA_W-1], sclk=0.
REQ-017 A half-period counter SHALL count CLK_DIV clk cycles per phase; SETUP, each SCLK half and HOLD/GAP last exactly CLK_DIV cycles each.
REQ-018 For bit k=1..DATA_W: sclk SHALL rise at T0+(2k-1)*CLK_DIV and fall at T0+2k*CLK_DIV.
REQ-019 miso SHALL be sampled into the rx shift register on the last clk cycle of each SCLK high phase, i.e. on the edge where sclk falls.
REQ-020 mosi SHALL advance to the next lower bit on each falling sclk edge except the last; after the last falling edge mosi holds its value.
REQ-021 After the DATA_W-th falling edge the FSM SHALL enter HOLD with ss=0 and sclk=0.
REQ-022 At T0+(2*DATA_W+1)*CLK_DIV: ss=1, rx_data updated, done=1 for one cycle, FSM enters GAP.
REQ-023 GAP SHALL keep ss=1 and busy=1 for CLK_DIV cycles, then enter IDLE with busy=0 at T0+(2*DATA_W+2)*CLK_DIV.
REQ-024 start while not in IDLE SHALL be ignored; there is no queuing.
REQ-025 tx_data changes after acceptance SHALL NOT affect the transfer in progress.
REQ-026 rx_data SHALL change only at the done pulse and otherwise hold its value.
REQ-027 sclk SHALL toggle only in XFER; exactly DATA_W rising edges per transfer.
REQ-028 The bit counter SHALL be wide enough for DATA_W with no wrap before the last bit.

Reset
REQ-029 rst=1 SHALL force immediately, independent of clk: ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, FSM=IDLE, counters=0.
REQ-030 Reset during a transfer SHALL abort it with no done pulse; rx_data SHALL read 0.
REQ-031 The first start after rst is released SHALL be accepted on the next rising clk edge.

Structure
REQ-032 A shared package spi_pkg SHALL hold the FSM state encodings, the DATA_W default and the SPI mode-0 constants, shared with spi_slave.
REQ-033 The half-period counter and tick generation SHALL be a sub-module, spi_clk_div (inputs: clk, rst, enable; output: one-cycle tick every CLK_DIV cycles).
REQ-034 All outputs SHALL be driven directly from flops (no combinational paths from inputs to outputs).

Verification
REQ-035 Loopback (miso=mosi), CLK_DIV=4, tx_data=0xA5 -> rx_data=0xA5; done at T0+68; busy low at T0+72.
REQ-036 miso tied 1, tx_data=0x00 -> rx_data=0xFF; mosi stays 0 throughout; exactly 8 sclk rising edges.
REQ-037 CLK_DIV=2, tx_data=0x3C into a spi_slave model that returns 0x96 -> rx 0x96; sclk period 4 clk cycles.
REQ-038 start pulsed at T0+10 during a transfer -> ignored; exactly one done pulse; next start is accepted only after busy=0.
REQ-039 rst asserted at T0+20 -> ss=1 and sclk=0 in the same cycle, no done pulse, rx_data=0; a following 0x5A loopback returns 0x5A.
REQ-040 Back-to-back starts held high -> ss high for at least CLK_DIV cycles between transfers; the two results 0x11 and 0xEE are correct.
